// File: rtl/ai_regs_pkg.sv
// ai_regs_pkg: register map and bit positions shared by the AI channel register file.
package ai_regs_pkg;

  // Word addresses of the fixed registers
  localparam int ADDR_CTRL            = 0;
  localparam int ADDR_STATUS          = 1;
  localparam int ADDR_PLAYER          = 2;
  localparam int ADDR_KEY             = 3;
  localparam int ADDR_ENEMY_SNAP_BASE = 4;

  // CTRL bit positions
  localparam int CTRL_SNAP_EN = 0;
  localparam int CTRL_IRQ_EN  = 1;

  // STATUS bit positions; the per-channel VALID mirror starts at STATUS_VALID_LSB
  localparam int STATUS_NEW       = 0;
  localparam int STATUS_OVF       = 1;
  localparam int STATUS_VALID_LSB = 2;

  // Command registers sit directly after the n enemy snapshot registers
  function automatic int enemy_cmd_base(input int n);
    return ADDR_ENEMY_SNAP_BASE + n;
  endfunction

endpackage

// File: rtl/ai_channel_regfile_if.sv
// ai_channel_regfile_if: Avalon-MM slave bus between the NIOS AI software and the register file.
interface ai_channel_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                  AI_CS;
  logic                  AI_READ;
  logic                  AI_WRITE;
  logic [DATA_W/8-1:0]   AI_BYTE_EN;
  logic [ADDR_W-1:0]     AI_ADDR;
  logic [DATA_W-1:0]     AI_WRITEDATA;
  logic [DATA_W-1:0]     AI_READDATA;
  logic                  AI_IRQ;

  modport master (
    output AI_CS, AI_READ, AI_WRITE, AI_BYTE_EN, AI_ADDR, AI_WRITEDATA,
    input  AI_READDATA, AI_IRQ
  );

  modport slave (
    input  AI_CS, AI_READ, AI_WRITE, AI_BYTE_EN, AI_ADDR, AI_WRITEDATA,
    output AI_READDATA, AI_IRQ
  );
endinterface

// File: rtl/ai_cmd_channel.sv
// ai_cmd_channel: one enemy command slot; holds the word, its VALID flag and flags overwrites.
module ai_cmd_channel
  import ai_regs_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                ready,
  output logic [DATA_W-1:0]   cmd,
  output logic                valid,
  output logic                ovf_pulse
);

  logic [DATA_W-1:0] merged;

  // Bytes not enabled keep the currently held command
  always_comb begin
    merged = cmd;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  // A write always leaves a command pending, even when the old one transfers in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd   <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      cmd   <= merged;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Overwriting a command the controller never took loses it
  assign ovf_pulse = wr_en & valid & ~ready;

endmodule

// File: rtl/ai_channel_regfile.sv
// ai_channel_regfile: frame-coherent snapshot registers plus per-enemy command channels for the NIOS AI.
module ai_channel_regfile
  import ai_regs_pkg::*;
#(
  parameter int NUM_ENEMIES = 4,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  ai_channel_regfile_if.slave           bus,
  output logic [DATA_W-1:0]             EXPORT_DATA,
  input  logic                          FRAME_STB,
  input  logic [DATA_W-1:0]             PLAYER_LOC,
  input  logic [7:0]                    KEYCODE,
  input  logic [NUM_ENEMIES*DATA_W-1:0] ENEMY_LOC,
  output logic [NUM_ENEMIES*DATA_W-1:0] ENEMY_CMD,
  output logic [NUM_ENEMIES-1:0]        ENEMY_CMD_VALID,
  input  logic [NUM_ENEMIES-1:0]        ENEMY_CMD_READY
);

  localparam int CMD_BASE = enemy_cmd_base(NUM_ENEMIES);

  logic [31:0]            addr_w;
  logic                   wr_stb;
  logic                   rd_stb;
  logic                   snap_fire;
  logic                   ovf_clr;
  logic [DATA_W-1:0]      ctrl_q;
  logic [DATA_W-1:0]      ctrl_merged;
  logic                   status_new;
  logic                   status_ovf;
  logic [DATA_W-1:0]      player_snap;
  logic [7:0]             key_snap;
  logic [DATA_W-1:0]      enemy_snap [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] cmd_wr;
  logic [NUM_ENEMIES-1:0] ovf_pulse;
  logic [DATA_W-1:0]      status_word;
  logic [DATA_W-1:0]      rd_mux;
  logic [DATA_W-1:0]      readdata_q;
  logic                   irq_q;

  assign addr_w    = 32'(bus.AI_ADDR);
  assign wr_stb    = bus.AI_CS & bus.AI_WRITE;
  assign rd_stb    = bus.AI_CS & bus.AI_READ;
  assign snap_fire = FRAME_STB & ctrl_q[CTRL_SNAP_EN];
  assign ovf_clr   = wr_stb && (addr_w == ADDR_STATUS) && bus.AI_BYTE_EN[0]
                     && bus.AI_WRITEDATA[STATUS_OVF];

  // Byte-enable merge for CTRL writes and per-channel command write strobes
  always_comb begin
    ctrl_merged = ctrl_q;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (bus.AI_BYTE_EN[b]) ctrl_merged[b*8 +: 8] = bus.AI_WRITEDATA[b*8 +: 8];
    end
    cmd_wr = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      cmd_wr[i] = wr_stb && (addr_w == 32'(CMD_BASE + i));
    end
  end

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_chan
    ai_cmd_channel #(.DATA_W(DATA_W)) u_chan (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .wr_en     (cmd_wr[g]),
      .byte_en   (bus.AI_BYTE_EN),
      .wr_data   (bus.AI_WRITEDATA),
      .ready     (ENEMY_CMD_READY[g]),
      .cmd       (ENEMY_CMD[g*DATA_W +: DATA_W]),
      .valid     (ENEMY_CMD_VALID[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  // CTRL register, also mirrored onto the LEDs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ctrl_q <= '0;
    else if (wr_stb && (addr_w == ADDR_CTRL)) ctrl_q <= ctrl_merged;
  end

  // All snapshots load together so software sees one coherent frame
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      player_snap <= '0;
      key_snap    <= '0;
      for (int i = 0; i < NUM_ENEMIES; i++) enemy_snap[i] <= '0;
    end else if (snap_fire) begin
      player_snap <= PLAYER_LOC;
      key_snap    <= KEYCODE;
      for (int i = 0; i < NUM_ENEMIES; i++) enemy_snap[i] <= ENEMY_LOC[i*DATA_W +: DATA_W];
    end
  end

  // NEW clears on a STATUS read unless a new frame lands that cycle; OVF is sticky until W1C
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      status_new <= 1'b0;
      status_ovf <= 1'b0;
    end else begin
      if (snap_fire) status_new <= 1'b1;
      else if (rd_stb && (addr_w == ADDR_STATUS)) status_new <= 1'b0;
      if (|ovf_pulse) status_ovf <= 1'b1;
      else if (ovf_clr) status_ovf <= 1'b0;
    end
  end

  // Read multiplexer; unmapped addresses read as zero
  always_comb begin
    status_word = '0;
    status_word[STATUS_NEW] = status_new;
    status_word[STATUS_OVF] = status_ovf;
    status_word[STATUS_VALID_LSB +: NUM_ENEMIES] = ENEMY_CMD_VALID;
    rd_mux = '0;
    if (addr_w == ADDR_CTRL)   rd_mux = ctrl_q;
    if (addr_w == ADDR_STATUS) rd_mux = status_word;
    if (addr_w == ADDR_PLAYER) rd_mux = player_snap;
    if (addr_w == ADDR_KEY)    rd_mux[7:0] = key_snap;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (addr_w == 32'(ADDR_ENEMY_SNAP_BASE + i)) rd_mux = enemy_snap[i];
      if (addr_w == 32'(CMD_BASE + i))             rd_mux = ENEMY_CMD[i*DATA_W +: DATA_W];
    end
  end

  // Registered read data (zero when idle) and interrupt, which trails NEW by one cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= rd_stb ? rd_mux : '0;
      irq_q      <= status_new & ctrl_q[CTRL_IRQ_EN];
    end
  end

  assign bus.AI_READDATA = readdata_q;
  assign bus.AI_IRQ      = irq_q;
  assign EXPORT_DATA     = ctrl_q;

endmodule

// File: tb/tb_ai_channel_regfile.sv
// tb_ai_channel_regfile: directed self-checking bench for the AI channel register file.
module tb_ai_channel_regfile;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_STATUS = 4'd1;
  localparam logic [3:0] A_PLAYER = 4'd2;
  localparam logic [3:0] A_KEY    = 4'd3;
  localparam logic [3:0] A_SNAP0  = 4'd4;
  localparam logic [3:0] A_CMD0   = 4'd8;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] EXPORT_DATA;
  logic        FRAME_STB;
  logic [15:0] PLAYER_LOC;
  logic [7:0]  KEYCODE;
  logic [63:0] ENEMY_LOC;
  logic [63:0] ENEMY_CMD;
  logic [3:0]  ENEMY_CMD_VALID;
  logic [3:0]  ENEMY_CMD_READY;

  int checks = 0;
  int errors = 0;
  logic [15:0] rd;

  // Free-running 100 MHz clock
  always #5 CLK = ~CLK;

  ai_channel_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus();

  ai_channel_regfile #(.NUM_ENEMIES(4), .DATA_W(16), .ADDR_W(4)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .bus             (bus),
    .EXPORT_DATA     (EXPORT_DATA),
    .FRAME_STB       (FRAME_STB),
    .PLAYER_LOC      (PLAYER_LOC),
    .KEYCODE         (KEYCODE),
    .ENEMY_LOC       (ENEMY_LOC),
    .ENEMY_CMD       (ENEMY_CMD),
    .ENEMY_CMD_VALID (ENEMY_CMD_VALID),
    .ENEMY_CMD_READY (ENEMY_CMD_READY)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic busWrite(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    bus.AI_CS = 1'b1; bus.AI_WRITE = 1'b1; bus.AI_ADDR = addr;
    bus.AI_WRITEDATA = data; bus.AI_BYTE_EN = be;
    tick();
    bus.AI_CS = 1'b0; bus.AI_WRITE = 1'b0; bus.AI_BYTE_EN = 2'b00;
  endtask

  task automatic busRead(input logic [3:0] addr, output logic [15:0] data);
    bus.AI_CS = 1'b1; bus.AI_READ = 1'b1; bus.AI_ADDR = addr;
    tick();
    bus.AI_CS = 1'b0; bus.AI_READ = 1'b0;
    data = bus.AI_READDATA;
  endtask

  task automatic applyStimulus_frame();
    FRAME_STB = 1'b1;
    tick();
    FRAME_STB = 1'b0;
  endtask

  // Directed scenario sequence
  initial begin
    RESET_N = 1'b0; FRAME_STB = 1'b0; PLAYER_LOC = '0; KEYCODE = '0;
    ENEMY_LOC = '0; ENEMY_CMD_READY = '0;
    bus.AI_CS = 1'b0; bus.AI_READ = 1'b0; bus.AI_WRITE = 1'b0;
    bus.AI_BYTE_EN = 2'b00; bus.AI_ADDR = '0; bus.AI_WRITEDATA = '0;
    repeat (3) tick();
    checkOutput("rst_readdata", 32'(bus.AI_READDATA), 32'h0);
    checkOutput("rst_irq", 32'(bus.AI_IRQ), 32'h0);
    checkOutput("rst_valid", 32'(ENEMY_CMD_VALID), 32'h0);
    checkOutput("rst_export", 32'(EXPORT_DATA), 32'h0);
    RESET_N = 1'b1;
    tick();

    // Reset in the middle of a pending command and an in-flight read
    busWrite(A_CTRL, 16'h0003, 2'b11);
    PLAYER_LOC = 16'h7777;
    applyStimulus_frame();
    tick();
    checkOutput("pre_rst_irq", 32'(bus.AI_IRQ), 32'h1);
    busWrite(A_CMD0 + 4'd1, 16'h5555, 2'b11);
    checkOutput("pre_rst_valid1", 32'(ENEMY_CMD_VALID), 32'h2);
    busRead(A_PLAYER, rd);
    checkOutput("pre_rst_read", 32'(rd), 32'h7777);
    RESET_N = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(ENEMY_CMD_VALID), 32'h0);
    checkOutput("async_rst_cmd", 32'(ENEMY_CMD[31:16]), 32'h0);
    checkOutput("async_rst_readdata", 32'(bus.AI_READDATA), 32'h0);
    checkOutput("async_rst_irq", 32'(bus.AI_IRQ), 32'h0);
    checkOutput("async_rst_export", 32'(EXPORT_DATA), 32'h0);
    tick();
    RESET_N = 1'b1;
    tick();

    // Snapshot with interrupt
    busWrite(A_CTRL, 16'h0003, 2'b11);
    checkOutput("export_ctrl", 32'(EXPORT_DATA), 32'h3);
    PLAYER_LOC = 16'h1234; KEYCODE = 8'h5A; ENEMY_LOC[32 +: 16] = 16'hBEEF;
    applyStimulus_frame();
    PLAYER_LOC = 16'h9999; KEYCODE = 8'h11; ENEMY_LOC = '1;
    checkOutput("irq_lag", 32'(bus.AI_IRQ), 32'h0);
    tick();
    checkOutput("irq_set", 32'(bus.AI_IRQ), 32'h1);
    busRead(A_PLAYER, rd);
    checkOutput("snap_player", 32'(rd), 32'h1234);
    busRead(A_KEY, rd);
    checkOutput("snap_key", 32'(rd), 32'h005A);
    busRead(A_SNAP0 + 4'd2, rd);
    checkOutput("snap_enemy2", 32'(rd), 32'hBEEF);
    busRead(A_STATUS, rd);
    checkOutput("status_new_set", 32'(rd[0]), 32'h1);
    busRead(A_STATUS, rd);
    checkOutput("status_new_clr", 32'(rd[0]), 32'h0);
    checkOutput("irq_clr", 32'(bus.AI_IRQ), 32'h0);
    tick();
    checkOutput("readdata_idle", 32'(bus.AI_READDATA), 32'h0);

    // Snapshots hold with SNAP_EN=0; CTRL byte enables
    busWrite(A_CTRL, 16'h0002, 2'b11);
    PLAYER_LOC = 16'h4444;
    applyStimulus_frame();
    busRead(A_PLAYER, rd);
    checkOutput("snap_hold", 32'(rd), 32'h1234);
    busRead(A_STATUS, rd);
    checkOutput("snap_hold_new", 32'(rd[0]), 32'h0);
    busWrite(A_CTRL, 16'hAB55, 2'b10);
    busRead(A_CTRL, rd);
    checkOutput("ctrl_byte_en", 32'(rd), 32'hAB02);
    checkOutput("export_byte_en", 32'(EXPORT_DATA), 32'hAB02);
    busWrite(A_CTRL, 16'h0003, 2'b11);

    // Handshake on channel 0 with a stalled controller
    busWrite(A_CMD0, 16'h00A5, 2'b11);
    checkOutput("hs_valid_rise", 32'(ENEMY_CMD_VALID), 32'h1);
    busRead(A_STATUS, rd);
    checkOutput("hs_status", 32'(rd), 32'h0004);
    busRead(A_CMD0, rd);
    checkOutput("hs_cmd_read", 32'(rd), 32'h00A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hs_valid_hold", 32'(ENEMY_CMD_VALID[0]), 32'h1);
      checkOutput("hs_cmd_hold", 32'(ENEMY_CMD[15:0]), 32'h00A5);
    end
    ENEMY_CMD_READY[0] = 1'b1;
    tick();
    ENEMY_CMD_READY[0] = 1'b0;
    checkOutput("hs_valid_fall", 32'(ENEMY_CMD_VALID[0]), 32'h0);
    checkOutput("hs_cmd_after", 32'(ENEMY_CMD[15:0]), 32'h00A5);

    // Overflow on channel 3 and W1C clear
    busWrite(A_CMD0 + 4'd3, 16'h1111, 2'b11);
    busWrite(A_CMD0 + 4'd3, 16'h2222, 2'b11);
    busRead(A_STATUS, rd);
    checkOutput("ovf_status", 32'(rd), 32'h0022);
    busRead(A_CMD0 + 4'd3, rd);
    checkOutput("ovf_cmd_read", 32'(rd), 32'h2222);
    checkOutput("ovf_cmd_port", 32'(ENEMY_CMD[48 +: 16]), 32'h2222);
    busWrite(A_STATUS, 16'h0002, 2'b10);
    busRead(A_STATUS, rd);
    checkOutput("ovf_w1c_byte1", 32'(rd), 32'h0022);
    busWrite(A_STATUS, 16'h0002, 2'b01);
    busRead(A_STATUS, rd);
    checkOutput("ovf_w1c_clear", 32'(rd), 32'h0020);
    ENEMY_CMD_READY[3] = 1'b1;
    tick();
    ENEMY_CMD_READY[3] = 1'b0;
    checkOutput("ovf_drain", 32'(ENEMY_CMD_VALID), 32'h0);

    // Write and transfer in the same cycle on channel 2: no overflow
    busWrite(A_CMD0 + 4'd2, 16'h3333, 2'b11);
    ENEMY_CMD_READY[2] = 1'b1;
    busWrite(A_CMD0 + 4'd2, 16'h4444, 2'b11);
    ENEMY_CMD_READY[2] = 1'b0;
    checkOutput("same_valid", 32'(ENEMY_CMD_VALID), 32'h4);
    checkOutput("same_cmd", 32'(ENEMY_CMD[32 +: 16]), 32'h4444);
    busRead(A_STATUS, rd);
    checkOutput("same_no_ovf", 32'(rd), 32'h0010);
    ENEMY_CMD_READY[2] = 1'b1;
    tick();
    ENEMY_CMD_READY[2] = 1'b0;

    // Partial byte write on channel 1
    busWrite(A_CMD0 + 4'd1, 16'hFFFF, 2'b11);
    busWrite(A_CMD0 + 4'd1, 16'h1200, 2'b10);
    busRead(A_CMD0 + 4'd1, rd);
    checkOutput("be_merge", 32'(rd), 32'h12FF);
    busWrite(A_STATUS, 16'h0002, 2'b01);
    ENEMY_CMD_READY[1] = 1'b1;
    tick();
    ENEMY_CMD_READY[1] = 1'b0;
    busRead(A_STATUS, rd);
    checkOutput("be_status_idle", 32'(rd), 32'h0000);

    // Read-only and unmapped addresses
    busWrite(A_PLAYER, 16'hDEAD, 2'b11);
    busRead(A_PLAYER, rd);
    checkOutput("ro_ignored", 32'(rd), 32'h1234);
    busWrite(4'd12, 16'hFFFF, 2'b11);
    busRead(4'd12, rd);
    checkOutput("unmapped_zero", 32'(rd), 32'h0);

    // Frame strobe coinciding with a STATUS read
    FRAME_STB = 1'b1;
    busRead(A_STATUS, rd);
    FRAME_STB = 1'b0;
    checkOutput("coll_old_new", 32'(rd[0]), 32'h0);
    busRead(A_STATUS, rd);
    checkOutput("coll_new_set", 32'(rd), 32'h0001);
    checkOutput("coll_irq", 32'(bus.AI_IRQ), 32'h1);
    busRead(A_PLAYER, rd);
    checkOutput("coll_snap", 32'(rd), 32'h4444);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ai_channel_regfile.md
# ai_channel_regfile

Parametrised Avalon-MM slave register file between the NIOS II AI software and the game hardware, supporting NUM_ENEMIES enemy channels. It takes frame-coherent snapshots of player, keyboard and enemy positions and raises an interrupt when a new snapshot is ready. It also delivers one command word per enemy to the game logic over a valid/ready handshake, holding each command until the enemy controller accepts it.

## Interface
- NUM_ENEMIES, 4, number of enemy channels (1..6)
- DATA_W, 16, Avalon data and location/command width; multiple of 8
- ADDR_W, 4, Avalon word-address width; 4+2*NUM_ENEMIES <= 2**ADDR_W
- CLK  in  1  system clock; single clock domain
- RESET_N  in  1  asynchronous, active-low reset
- AI_CS, AI_READ, AI_WRITE  in  1 each  Avalon-MM chip select / read / write
- AI_BYTE_EN  in  DATA_W/8  byte enables for writes
- AI_ADDR  in  ADDR_W  word address
- AI_WRITEDATA  in  DATA_W  write data
- AI_READDATA  out  DATA_W  read data, registered
- AI_IRQ  out  1  level interrupt to NIOS
- EXPORT_DATA  out  DATA_W  mirror of CTRL, to LEDs
- FRAME_STB  in  1  one-cycle pulse at frame boundary
- PLAYER_LOC  in  DATA_W  live player location
- KEYCODE  in  8  live keycode
- ENEMY_LOC  in  NUM_ENEMIES*DATA_W  live enemy locations; channel i at [i*DATA_W +: DATA_W]
- ENEMY_CMD  out  NUM_ENEMIES*DATA_W  held command per channel
- ENEMY_CMD_VALID  out  NUM_ENEMIES  command pending per channel
- ENEMY_CMD_READY  in  NUM_ENEMIES  enemy controller accepts command

## Operation
- Address map (word):
  - 0 CTRL, RW: bit0 SNAP_EN, bit1 IRQ_EN, other bits RW scratch.
  - 1 STATUS: bit0 NEW (RO; cleared by read), bit1 OVF (W1C), bits[2+:NUM_ENEMIES] mirror ENEMY_CMD_VALID (RO).
  - 2 PLAYER_SNAP, RO.
  - 3 KEY_SNAP, RO, zero-extended.
  - 4..3+N ENEMY_SNAP[i], RO.
  - 4+N..3+2N ENEMY_CMD[i], RW.
- Byte enables apply to CTRL and ENEMY_CMD writes.
- STATUS W1C uses byte 0 only.
- Writes to RO or unmapped addresses are ignored; reads of unmapped addresses return 0.
- Snapshot: on FRAME_STB with SNAP_EN=1, all snapshot registers load their live inputs in the same cycle and NEW is set.
- With SNAP_EN=0, FRAME_STB is ignored and snapshots hold.
- AI_IRQ = NEW & IRQ_EN, registered.
- Command channel i: a write to ENEMY_CMD[i] updates the held word and sets VALID[i].
- Channel i handshake: transfer occurs when VALID[i] & READY[i]; VALID[i] clears the next cycle and ENEMY_CMD[i] holds its value.
- Write to ENEMY_CMD[i] while VALID[i]=1 with no transfer that cycle: word overwritten, VALID stays 1, OVF set (sticky).
- Write and transfer in the same cycle: new word pending, VALID stays 1, no OVF.
- FRAME_STB coinciding with a STATUS read: the read returns the old NEW; NEW ends set (strobe wins).
- Reading ENEMY_CMD[i] returns the held word.
- Reset values: all registers 0, AI_READDATA 0, AI_IRQ 0, ENEMY_CMD_VALID 0, ENEMY_CMD 0, EXPORT_DATA 0.

## Timing
- Read latency is 1: AI_READDATA is valid on the cycle after AI_CS&AI_READ, and 0 otherwise.
- Write takes effect at the clock edge of AI_CS&AI_WRITE; effects are visible to a read issued next cycle.
- No wait states; Avalon waitrequest is not used.
- Snapshot registers and NEW update at the FRAME_STB edge.
- AI_IRQ follows NEW one cycle later.
- ENEMY_CMD_VALID rises the cycle after the write and falls the cycle after the transfer.
- RESET_N assertion at any time clears state immediately, including pending commands (dropped, no transfer) and in-flight read data.

## Structure
- Package ai_regs_pkg holds:
  - address constants ADDR_CTRL, ADDR_STATUS, ADDR_PLAYER, ADDR_KEY, ADDR_ENEMY_SNAP_BASE, and the function enemy_cmd_base(N);
  - CTRL/STATUS bit-index constants.
- Sub-module ai_cmd_channel, instantiated NUM_ENEMIES times via generate. It holds the command word, the VALID flag and the byte-enable merge, and emits an overflow pulse to the top-level OVF logic.

## Test plan
- Reset: hold RESET_N=0 mid-command with VALID[1]=1 → VALID=0, ENEMY_CMD=0, AI_READDATA=0, AI_IRQ=0.
- Snapshot: CTRL=0x3, PLAYER_LOC=0x1234, ENEMY_LOC[2]=0xBEEF, pulse FRAME_STB, then change inputs.
  - Read addr 2 → 0x1234; read ENEMY_SNAP[2] → 0xBEEF.
  - AI_IRQ=1 one cycle after NEW; reading STATUS returns bit0=1, next STATUS read returns bit0=0.
- Handshake: write 0x00A5 to ENEMY_CMD[0] with READY held 0 for 5 cycles, then 1.
  - VALID high until 1 cycle after the accept; ENEMY_CMD[0]=0x00A5 throughout.
- Overflow: two writes to ENEMY_CMD[3] with READY=0.
  - STATUS.OVF=1 and the second value is held; writing 0x2 to STATUS clears OVF.
- Byte enables: ENEMY_CMD[1]=0xFFFF, then write 0x1200 with BYTE_EN=2'b10 → reads 0x12FF.
- Simultaneous: FRAME_STB in the same cycle as a STATUS read with NEW=0 → read returns bit0=0, the next read returns bit0=1.
